hazard_detection_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS-32 core. It sits alongside the ID/EX pipeline register and drives the write enables and bubble/flush controls that feed it. It detects load-use hazards between the load in EX and the instruction in ID, and holds the PC and IF/ID register for a programmable number of cycles while injecting bubbles into ID/EX. It flushes IF/ID and ID/EX on a taken branch resolved in EX, and keeps saturating stall and flush statistics counters.

---
 rtl/hazard_detection_unit.sv | 198 +++++++++++++++++++
 tb/tb_hazard_detection_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit
// Load-use and taken-branch hazard controller for the 5-stage MIPS-32 core.
// It sits beside the ID/EX pipeline register. It drives the PC and IF/ID
// write enables, the IF/ID flush and the ID/EX bubble controls. It also keeps
// saturating statistics counters for stall cycles and taken-branch events.
//
// Control outputs are combinational from the FSM state and the current inputs,
// so a hazard or a taken branch is answered in the cycle it appears.
// The FSM tracks stalls and flushes that last more than one cycle.
// A 3-bit down-counter holds the number of cycles still to run in STALL/FLUSH.
// Priority in every state is:
//   1. taken branch
//   2. an already running stall/flush
//   3. a new load-use hazard
//
// fsm_state_out is a debug view of the FSM state (0=RUN, 1=STALL, 2=FLUSH).

module hazard_detection_unit #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             ID_EX_MemRead_in,
  input  logic [4:0]       ID_EX_Rt_in,
  input  logic [4:0]       IF_ID_Rs_in,
  input  logic [4:0]       IF_ID_Rt_in,
  input  logic             IF_ID_UsesRt_in,
  input  logic             branch_taken_in,
  output logic             PC_Write_out,
  output logic             IF_ID_Write_out,
  output logic             IF_ID_Flush_out,
  output logic             ID_EX_Bubble_out,
  output logic [CNT_W-1:0] stall_count_out,
  output logic [CNT_W-1:0] flush_count_out,
  output logic [1:0]       fsm_state_out
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Value loaded into cnt when a multi-cycle stall/flush starts.
  // The first cycle of a stall/flush is spent in RUN, so cnt counts the
  // cycles that remain after it.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam bit         STALL_MULTI  = (LOAD_STALL_CYCLES > 1);
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  logic hazard;
  logic rs_match;
  logic rt_match;

  // FSM-driven control values, before the reset override is applied.
  logic fsm_pc_write;
  logic fsm_if_id_write;
  logic fsm_flush;
  logic fsm_bubble;

  // Load-use detection: the load in EX writes a register that ID reads.
  // Register 0 is never a real dependency.
  always_comb begin
    rs_match = (ID_EX_Rt_in == IF_ID_Rs_in);
    rt_match = IF_ID_UsesRt_in && (ID_EX_Rt_in == IF_ID_Rt_in);
    hazard   = ID_EX_MemRead_in && (ID_EX_Rt_in != 5'd0) && (rs_match || rt_match);
  end

  // Next-state and control decode. A taken branch always wins.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fsm_pc_write    = 1'b1;
    fsm_if_id_write = 1'b1;
    fsm_flush       = 1'b0;
    fsm_bubble      = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_taken_in) begin
          fsm_flush  = 1'b1;
          fsm_bubble = 1'b1;
          if (FLUSH_MULTI) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (hazard) begin
          fsm_pc_write    = 1'b0;
          fsm_if_id_write = 1'b0;
          fsm_bubble      = 1'b1;
          if (STALL_MULTI) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end

      STALL: begin
        if (branch_taken_in) begin
          // The branch kills the instruction in ID, so the stall is dropped.
          fsm_flush  = 1'b1;
          fsm_bubble = 1'b1;
          if (FLUSH_MULTI) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end else begin
          fsm_pc_write    = 1'b0;
          fsm_if_id_write = 1'b0;
          fsm_bubble      = 1'b1;
          cnt_d           = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
      end

      FLUSH: begin
        fsm_flush  = 1'b1;
        fsm_bubble = 1'b1;
        if (branch_taken_in) begin
          // A fresh branch restarts the full flush window.
          cnt_d = FLUSH_RELOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // While reset is held, freeze the front end and keep bubbling ID/EX.
  // This takes effect as soon as reset rises, independent of the clock.
  always_comb begin
    if (reset_in) begin
      PC_Write_out     = 1'b0;
      IF_ID_Write_out  = 1'b0;
      IF_ID_Flush_out  = 1'b1;
      ID_EX_Bubble_out = 1'b1;
    end else begin
      PC_Write_out     = fsm_pc_write;
      IF_ID_Write_out  = fsm_if_id_write;
      IF_ID_Flush_out  = fsm_flush;
      ID_EX_Bubble_out = fsm_bubble;
    end
  end

  // State and remaining-cycle register.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating stall-cycle counter: one count per edge with the PC held.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      stall_count_out <= '0;
    end else if (!PC_Write_out && (stall_count_out != CNT_MAX)) begin
      stall_count_out <= stall_count_out + 1'b1;
    end
  end

  // Saturating taken-branch counter: one count per branch_taken_in edge.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      flush_count_out <= '0;
    end else if (branch_taken_in && (flush_count_out != CNT_MAX)) begin
      flush_count_out <= flush_count_out + 1'b1;
    end
  end

  assign fsm_state_out = state_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit
// Three copies of hazard_detection_unit with different parameters are driven
// from the same inputs:
//   inst0: LOAD_STALL_CYCLES=1, FLUSH_CYCLES=1, CNT_W=16
//   inst1: LOAD_STALL_CYCLES=2, FLUSH_CYCLES=3, CNT_W=4
//   inst2: LOAD_STALL_CYCLES=4, FLUSH_CYCLES=2, CNT_W=8
// The reference model tracks the cycles of stall and of flush still owed,
// plus plain integer counters. For each cycle it pushes one expected word per
// instance into exp_q.
// Expected word layout: {PC_Write, IF_ID_Write, Flush, Bubble, stall_count[15:0], flush_count[15:0]}.

module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rt = 5'd0;
  logic [4:0] id_rs = 5'd0;
  logic [4:0] id_rt = 5'd0;
  logic       uses_rt = 1'b0;
  logic       br_taken = 1'b0;

  logic        pc0, ifw0, fl0, bub0;
  logic        pc1, ifw1, fl1, bub1;
  logic        pc2, ifw2, fl2, bub2;
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
  logic [7:0]  sc2, fc2;
  logic [1:0]  st0, st1, st2;

  logic [35:0] obs [3];
  logic [35:0] exp_q [$];
  localparam logic [35:0] RESET_WORD = {4'b0011, 32'h0};

  int checks = 0;
  int errors = 0;

  // Model parameters and state, indexed by instance.
  int  lsc_p [3] = '{1, 2, 4};
  int  fc_p  [3] = '{1, 3, 2};
  int  cmax  [3] = '{65535, 15, 255};
  int  stall_left [3];
  int  flush_left [3];
  int  scnt [3];
  int  fcnt [3];
  int  n_stall_left [3];
  int  n_flush_left [3];
  int  n_scnt [3];
  int  n_fcnt [3];
  bit  pending = 1'b0;

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- DUTs ----------------
  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) u0 (
    .clk(clk), .reset_in(reset_in), .ID_EX_MemRead_in(mem_read), .ID_EX_Rt_in(ex_rt),
    .IF_ID_Rs_in(id_rs), .IF_ID_Rt_in(id_rt), .IF_ID_UsesRt_in(uses_rt),
    .branch_taken_in(br_taken), .PC_Write_out(pc0), .IF_ID_Write_out(ifw0),
    .IF_ID_Flush_out(fl0), .ID_EX_Bubble_out(bub0), .stall_count_out(sc0),
    .flush_count_out(fc0), .fsm_state_out(st0));

  hazard_detection_unit #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(4)) u1 (
    .clk(clk), .reset_in(reset_in), .ID_EX_MemRead_in(mem_read), .ID_EX_Rt_in(ex_rt),
    .IF_ID_Rs_in(id_rs), .IF_ID_Rt_in(id_rt), .IF_ID_UsesRt_in(uses_rt),
    .branch_taken_in(br_taken), .PC_Write_out(pc1), .IF_ID_Write_out(ifw1),
    .IF_ID_Flush_out(fl1), .ID_EX_Bubble_out(bub1), .stall_count_out(sc1),
    .flush_count_out(fc1), .fsm_state_out(st1));

  hazard_detection_unit #(.LOAD_STALL_CYCLES(4), .FLUSH_CYCLES(2), .CNT_W(8)) u2 (
    .clk(clk), .reset_in(reset_in), .ID_EX_MemRead_in(mem_read), .ID_EX_Rt_in(ex_rt),
    .IF_ID_Rs_in(id_rs), .IF_ID_Rt_in(id_rt), .IF_ID_UsesRt_in(uses_rt),
    .branch_taken_in(br_taken), .PC_Write_out(pc2), .IF_ID_Write_out(ifw2),
    .IF_ID_Flush_out(fl2), .ID_EX_Bubble_out(bub2), .stall_count_out(sc2),
    .flush_count_out(fc2), .fsm_state_out(st2));

  always_comb begin
    obs[0] = {pc0, ifw0, fl0, bub0, sc0, fc0};
    obs[1] = {pc1, ifw1, fl1, bub1, 12'd0, sc1, 12'd0, fc1};
    obs[2] = {pc2, ifw2, fl2, bub2, 8'd0, sc2, 8'd0, fc2};
  end

  // ---------------- model / driver ----------------
  function automatic logic [17:0] mk(input logic mr, input int rt, input int rs,
                                     input int irt, input logic uses, input logic br);
    return {mr, 5'(rt), 5'(rs), 5'(irt), uses, br};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      stall_left[i] = 0;
      flush_left[i] = 0;
      scnt[i]       = 0;
      fcnt[i]       = 0;
    end
    pending = 1'b0;
    exp_q.delete();
  endtask

  // Advance to the next cycle, drive one input vector, and queue the expected
  // outputs of every instance for that cycle.
  task automatic apply(input logic [17:0] v);
    logic hz, p, w, f, b;
    if (pending) begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        stall_left[i] = n_stall_left[i];
        flush_left[i] = n_flush_left[i];
        scnt[i]       = n_scnt[i];
        fcnt[i]       = n_fcnt[i];
      end
    end
    @(negedge clk);
    mem_read = v[17];
    ex_rt    = v[16:12];
    id_rs    = v[11:7];
    id_rt    = v[6:2];
    uses_rt  = v[1];
    br_taken = v[0];
    #1;
    hz = mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (uses_rt && ex_rt == id_rt));
    for (int i = 0; i < 3; i++) begin
      n_stall_left[i] = 0;
      n_flush_left[i] = 0;
      if (br_taken) begin
        {p, w, f, b} = 4'b1111;
        n_flush_left[i] = fc_p[i] - 1;
      end else if (flush_left[i] > 0) begin
        {p, w, f, b} = 4'b1111;
        n_flush_left[i] = flush_left[i] - 1;
      end else if (stall_left[i] > 0) begin
        {p, w, f, b} = 4'b0001;
        n_stall_left[i] = stall_left[i] - 1;
      end else if (hz) begin
        {p, w, f, b} = 4'b0001;
        n_stall_left[i] = lsc_p[i] - 1;
      end else begin
        {p, w, f, b} = 4'b1100;
      end
      exp_q.push_back({p, w, f, b, 16'(scnt[i]), 16'(fcnt[i])});
      n_scnt[i] = (!p && scnt[i] < cmax[i]) ? scnt[i] + 1 : scnt[i];
      n_fcnt[i] = (br_taken && fcnt[i] < cmax[i]) ? fcnt[i] + 1 : fcnt[i];
    end
    pending = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_in = 1'b1;
    #3;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== RESET_WORD) begin
        errors++;
        $display("FAIL reset inst%0d got %h exp %h", i, obs[i], RESET_WORD);
      end
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== RESET_WORD) begin
        errors++;
        $display("FAIL reset_held inst%0d got %h exp %h", i, obs[i], RESET_WORD);
      end
    end
    @(negedge clk);
    reset_in = 1'b0;
    model_reset();
  endtask

  task automatic test_load_use();
    logic [17:0] seq [$];
    logic [35:0] e;
    seq = '{mk(1, 8, 8, 0, 0, 0), mk(1, 9, 8, 0, 0, 0), mk(0, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0)};
    foreach (seq[k]) begin
      apply(seq[k]);
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL load_use step%0d inst%0d got %h exp %h", k, i, obs[i], e);
        end
      end
    end
  endtask

  task automatic test_non_hazards();
    logic [17:0] seq [$];
    logic [35:0] e;
    seq = '{mk(1, 0, 0, 0, 1, 0), mk(1, 5, 3, 5, 0, 0), mk(0, 5, 5, 5, 1, 0),
            mk(1, 5, 3, 5, 1, 0), mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0)};
    foreach (seq[k]) begin
      apply(seq[k]);
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL non_hazard step%0d inst%0d got %h exp %h", k, i, obs[i], e);
        end
      end
    end
  endtask

  task automatic test_branch_hazard();
    logic [17:0] seq [$];
    logic [35:0] e;
    // branch+hazard together, idle, mid-stall branch, flush reload, drain
    seq = '{mk(1, 8, 8, 0, 0, 1), mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 0, 0, 0), mk(1, 7, 2, 7, 1, 0), mk(0, 0, 0, 0, 0, 1),
            mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 1), mk(1, 3, 3, 0, 0, 0),
            mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0),
            mk(0, 0, 0, 0, 0, 0)};
    foreach (seq[k]) begin
      apply(seq[k]);
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL branch step%0d inst%0d got %h exp %h", k, i, obs[i], e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] seq [$];
    logic [35:0] e;
    // load feeding a load, repeated so each stall ends into a fresh hazard
    for (int k = 0; k < 10; k++) seq.push_back(mk(1, 4 + (k % 2), 4 + (k % 2), 0, 0, 0));
    for (int k = 0; k < 4; k++) seq.push_back(mk(0, 0, 0, 0, 0, 0));
    foreach (seq[k]) begin
      apply(seq[k]);
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL back_to_back step%0d inst%0d got %h exp %h", k, i, obs[i], e);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [35:0] e;
    for (int k = 0; k < 21; k++) begin
      apply((k < 20) ? mk(1, 6, 6, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL saturation step%0d inst%0d got %h exp %h", k, i, obs[i], e);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      apply(mk(0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) e = exp_q.pop_front();
      checks++;
      if (sc1 !== 4'd15) begin
        errors++;
        $display("FAIL saturation_hold got %0d exp 15", sc1);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [35:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 aborts a stall in its 2nd cycle, pass 1 aborts a flush
      apply((pass == 0) ? mk(1, 8, 8, 0, 0, 0) : mk(0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL abort_pre%0d inst%0d got %h exp %h", pass, i, obs[i], e);
        end
      end
      apply(mk(0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL abort_mid%0d inst%0d got %h exp %h", pass, i, obs[i], e);
        end
      end
      #5;
      reset_in = 1'b1;
      #2;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== RESET_WORD) begin
          errors++;
          $display("FAIL abort_reset%0d inst%0d got %h exp %h", pass, i, obs[i], RESET_WORD);
        end
      end
      model_reset();
      @(negedge clk);
      reset_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
        apply(mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
          e = exp_q.pop_front();
          checks++;
          if (obs[i] !== e) begin
            errors++;
            $display("FAIL abort_post%0d step%0d inst%0d got %h exp %h", pass, k, i, obs[i], e);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [35:0] e;
    for (int k = 0; k < 400; k++) begin
      apply(mk(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0)));
      for (int i = 0; i < 3; i++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[i] !== e) begin
          errors++;
          $display("FAIL random step%0d inst%0d got %h exp %h", k, i, obs[i], e);
        end
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_load_use();
    test_non_hazards();
    test_branch_hazard();
    test_back_to_back();
    test_saturation();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
